// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic elastic pipeline stage register for the five-stage MIPS core. One
// instance sits between each pair of stages (D/E/M/W) and carries the
// instruction word, PC+4, an exception code and an opaque payload across a
// valid/ready handshake.
//
// Storage is a main entry (M, drives the out_* side) plus a skid entry (S).
// in_ready comes straight from a flop, so it never depends combinationally on
// out_ready. Outputs come only from the M flops.
//
// The exception code carried forward follows a first-exception-wins rule: an
// upstream code beats a locally detected one. A beat whose final code is
// selected in NOP_EXC_MASK has its instruction forced to 0 (NOP).
//
// Parameters:
//   DATA_W        payload width
//   EXC_W         exception code width
//   NOP_EXC_MASK  bit k set: final exception code k forces instr to 0
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   flush      in   empty the stage (exception/interrupt)
//   in_valid   in   upstream beat valid
//   in_ready   out  stage can accept a beat (registered)
//   in_kill    in   accepted beat is discarded
//   in_instr   in   instruction word
//   in_pc4     in   PC+4
//   in_exc     in   exception code from earlier stage, 0 = none
//   loc_exc    in   exception code detected by the feeding stage, 0 = none
//   in_data    in   opaque payload
//   out_valid  out  main entry holds a beat
//   out_ready  in   downstream accepts
//   out_instr  out  instruction (0 when empty or NOP-converted)
//   out_pc4    out  PC+4
//   out_exc    out  merged exception code
//   out_data   out  payload
//   stall_cnt  out  (only with STALL_PERF_CNT_EN) cycles with out_valid & ~out_ready
//
// Build option:
//   STALL_PERF_CNT_EN  when defined, adds the stall_cnt port and counter.
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int          DATA_W       = 128,
   parameter int          EXC_W        = 5,
   parameter logic [31:0] NOP_EXC_MASK = 32'h0000_0410
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_kill,
   input  logic [31:0]       in_instr,
   input  logic [31:0]       in_pc4,
   input  logic [EXC_W-1:0]  in_exc,
   input  logic [EXC_W-1:0]  loc_exc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc4,
   output logic [EXC_W-1:0]  out_exc,
   output logic [DATA_W-1:0] out_data
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   typedef struct packed {
      logic              valid;
      logic [31:0]       instr;
      logic [31:0]       pc4;
      logic [EXC_W-1:0]  exc;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t m_q, m_d;
   entry_t s_q, s_d;
   entry_t beat_in;
   logic   in_ready_q;

   logic             accept;
   logic             store;
   logic             drain;
   logic [EXC_W-1:0] exc_m;
   logic             nop_hit;

   // ---------------------------------------------------------------------------
   // Exception merge and NOP conversion of the incoming beat
   // ---------------------------------------------------------------------------
   assign exc_m = (in_exc != '0) ? in_exc : loc_exc;

   // Only codes 0..31 can be selected by the mask; wider codes with any upper
   // bit set never convert.
   generate
      if (EXC_W <= 5) begin : g_nop_narrow
         assign nop_hit = NOP_EXC_MASK[exc_m];
      end else begin : g_nop_wide
         assign nop_hit = (exc_m[EXC_W-1:5] == '0) && NOP_EXC_MASK[exc_m[4:0]];
      end
   endgenerate

   always_comb begin
      beat_in       = '0;
      beat_in.valid = 1'b1;
      beat_in.instr = nop_hit ? 32'h0 : in_instr;
      beat_in.pc4   = in_pc4;
      beat_in.exc   = exc_m;
      beat_in.data  = in_data;
   end

   // ---------------------------------------------------------------------------
   // Handshake terms
   // ---------------------------------------------------------------------------
   assign accept = in_valid & in_ready_q;
   assign store  = accept & ~in_kill;   // killed beats complete the handshake only
   assign drain  = m_q.valid & out_ready;

   // ---------------------------------------------------------------------------
   // Next-state of the two entries
   // ---------------------------------------------------------------------------
   always_comb begin
      m_d = m_q;
      s_d = s_q;
      if (flush) begin
         // Whatever drains this cycle was already presented on out_*; the
         // stage is empty afterwards and a concurrent accept is dropped.
         m_d = '0;
         s_d = '0;
      end else if (s_q.valid) begin
         // in_ready is low while S is full, so no accept can occur here.
         if (drain) begin
            m_d = s_q;
            s_d = '0;
         end
      end else begin
         if (store && (!m_q.valid || drain)) begin
            m_d = beat_in;
         end else if (store) begin
            s_d = beat_in;
         end else if (drain) begin
            // Empty entries hold all-zero fields so bubbles read as NOPs.
            m_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_q        <= '0;
         s_q        <= '0;
         in_ready_q <= 1'b1;
      end else begin
         m_q        <= m_d;
         s_q        <= s_d;
         in_ready_q <= ~s_d.valid;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs, all from flops
   // ---------------------------------------------------------------------------
   assign in_ready  = in_ready_q;
   assign out_valid = m_q.valid;
   assign out_instr = m_q.instr;
   assign out_pc4   = m_q.pc4;
   assign out_exc   = m_q.exc;
   assign out_data  = m_q.data;

`ifdef STALL_PERF_CNT_EN
   // ---------------------------------------------------------------------------
   // Downstream back-pressure counter; wraps, survives flush.
   // ---------------------------------------------------------------------------
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= 32'h0;
      end else if (m_q.valid && !out_ready) begin
         stall_cnt_q <= stall_cnt_q + 32'h1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Scoreboard bench for pipe_stage_skid. Every accepted, non-killed, non-flushed
// beat is pushed as its expected output; every drain pops and compares.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int          DATA_W = 128;
   localparam int          EXC_W  = 5;
   localparam logic [31:0] NOP_MASK = 32'h0000_0410;   // codes 4 and 10

   typedef struct {
      logic [31:0]       instr;
      logic [31:0]       pc4;
      logic [EXC_W-1:0]  exc;
      logic [DATA_W-1:0] data;
   } beat_t;

   logic              clk;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              in_kill;
   logic [31:0]       in_instr;
   logic [31:0]       in_pc4;
   logic [EXC_W-1:0]  in_exc;
   logic [EXC_W-1:0]  loc_exc;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [31:0]       out_pc4;
   logic [EXC_W-1:0]  out_exc;
   logic [DATA_W-1:0] out_data;
`ifdef STALL_PERF_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   int    n_checks = 0;
   int    n_fail   = 0;
   beat_t sb[$];

   pipe_stage_skid #(
      .DATA_W       (DATA_W),
      .EXC_W        (EXC_W),
      .NOP_EXC_MASK (NOP_MASK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_kill   (in_kill),
      .in_instr  (in_instr),
      .in_pc4    (in_pc4),
      .in_exc    (in_exc),
      .loc_exc   (loc_exc),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_pc4   (out_pc4),
      .out_exc   (out_exc),
      .out_data  (out_data)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t model(input logic [31:0] instr, input logic [31:0] pc4,
                                   input logic [EXC_W-1:0] ie, input logic [EXC_W-1:0] le,
                                   input logic [DATA_W-1:0] d);
      beat_t b;
      logic [31:0] mask;
      mask    = NOP_MASK;
      b.exc   = (ie != 0) ? ie : le;
      b.instr = mask[b.exc] ? 32'h0 : instr;
      b.pc4   = pc4;
      b.data  = d;
      return b;
   endfunction

   // Scoreboard monitor, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (!out_valid) begin
            check("bubble_instr", {96'h0, out_instr}, 128'h0);
            check("bubble_data", out_data, 128'h0);
         end
         if (out_valid && out_ready) begin
            check("sb_has_entry", {127'h0, sb.size() != 0}, 128'h1);
            if (sb.size() != 0) begin
               beat_t e;
               e = sb.pop_front();
               $display("OUT instr=%08h pc4=%08h exc=%0d data=%0h", out_instr, out_pc4, out_exc, out_data);
               check("sb_instr", {96'h0, out_instr}, {96'h0, e.instr});
               check("sb_pc4", {96'h0, out_pc4}, {96'h0, e.pc4});
               check("sb_exc", {123'h0, out_exc}, {123'h0, e.exc});
               check("sb_data", out_data, e.data);
            end
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready && !in_kill) begin
            sb.push_back(model(in_instr, in_pc4, in_exc, loc_exc, in_data));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc4,
                          input logic [EXC_W-1:0] ie, input logic [EXC_W-1:0] le,
                          input logic [DATA_W-1:0] d, input logic k);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc4   = pc4;
      in_exc   = ie;
      loc_exc  = le;
      in_data  = d;
      in_kill  = k;
   endtask

   // Holds the presented beat until a cycle with in_ready high has passed.
   task automatic wait_accept();
      int budget;
      bit acc;
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 20) begin
         acc = in_ready;
         step();
         budget++;
      end
      check("accept_timeout", {127'h0, acc}, 128'h1);
      in_valid = 1'b0;
      in_kill  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_kill   = 1'b0;
      in_instr  = 32'h0;
      in_pc4    = 32'h0;
      in_exc    = '0;
      loc_exc   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      do_reset();

      // Reset state
      check("rst_out_valid", {127'h0, out_valid}, 128'h0);
      check("rst_out_instr", {96'h0, out_instr}, 128'h0);
      check("rst_out_pc4", {96'h0, out_pc4}, 128'h0);
      check("rst_out_exc", {123'h0, out_exc}, 128'h0);
      check("rst_out_data", out_data, 128'h0);
      check("rst_in_ready", {127'h0, in_ready}, 128'h1);
`ifdef STALL_PERF_CNT_EN
      check("rst_stall_cnt", {96'h0, stall_cnt}, 128'h0);
`endif

      // Single beat, one-cycle latency
      out_ready = 1'b1;
      present(32'h8C01_0004, 32'h3004, 5'd0, 5'd0, 128'h1111, 1'b0);
      wait_accept();
      check("lat_out_valid", {127'h0, out_valid}, 128'h1);
      check("lat_out_instr", {96'h0, out_instr}, 128'h8C01_0004);
      check("lat_out_pc4", {96'h0, out_pc4}, 128'h3004);
      check("lat_out_exc", {123'h0, out_exc}, 128'h0);

      // Exception merge and NOP conversion
      present(32'hFC00_0000, 32'h3008, 5'd0, 5'd10, 128'h2222, 1'b0);
      wait_accept();
      check("ri_out_exc", {123'h0, out_exc}, 128'd10);
      check("ri_out_instr", {96'h0, out_instr}, 128'h0);
      present(32'hFC00_0000, 32'h300C, 5'd4, 5'd10, 128'h3333, 1'b0);
      wait_accept();
      check("first_exc_wins", {123'h0, out_exc}, 128'd4);
      check("adel_out_instr", {96'h0, out_instr}, 128'h0);
      present(32'h2001_0005, 32'h3010, 5'd0, 5'd12, 128'h4444, 1'b0);
      wait_accept();
      check("ov_out_exc", {123'h0, out_exc}, 128'd12);
      check("ov_keep_instr", {96'h0, out_instr}, 128'h2001_0005);
      step();

      // Back-pressure: A in M, B in S, C held
      out_ready = 1'b0;
      present(32'hAAAA_0001, 32'h4004, 5'd0, 5'd0, 128'hA, 1'b0);
      wait_accept();
      present(32'hBBBB_0002, 32'h4008, 5'd0, 5'd0, 128'hB, 1'b0);
      wait_accept();
      present(32'hCCCC_0003, 32'h400C, 5'd0, 5'd0, 128'hC, 1'b0);
      check("full_in_ready", {127'h0, in_ready}, 128'h0);
      check("full_head_a", {96'h0, out_instr}, 128'hAAAA_0001);
      step();
      check("full_hold_in_ready", {127'h0, in_ready}, 128'h0);
      check("full_hold_head_a", {96'h0, out_instr}, 128'hAAAA_0001);
      out_ready = 1'b1;
      wait_accept();
      check("order_head_c", {96'h0, out_instr}, 128'hCCCC_0003);
      repeat (2) step();

      // Flush with both entries full and a beat presented
      out_ready = 1'b0;
      present(32'h1111_0001, 32'h5004, 5'd0, 5'd0, 128'h51, 1'b0);
      wait_accept();
      present(32'h1111_0002, 32'h5008, 5'd0, 5'd0, 128'h52, 1'b0);
      wait_accept();
      present(32'hDEAD_0001, 32'h500C, 5'd0, 5'd0, 128'h53, 1'b0);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_out_valid", {127'h0, out_valid}, 128'h0);
      check("flush_out_instr", {96'h0, out_instr}, 128'h0);
      check("flush_out_pc4", {96'h0, out_pc4}, 128'h0);
      check("flush_out_exc", {123'h0, out_exc}, 128'h0);
      check("flush_out_data", out_data, 128'h0);
      check("flush_in_ready", {127'h0, in_ready}, 128'h1);

      // Flush while the stage is ready: the beat is dropped
      out_ready = 1'b1;
      present(32'hDEAD_0002, 32'h5010, 5'd0, 5'd0, 128'h54, 1'b0);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_drop_valid", {127'h0, out_valid}, 128'h0);
      step();
      check("flush_drop_valid2", {127'h0, out_valid}, 128'h0);

      // Flush concurrent with a drain: current M still delivered
      out_ready = 1'b0;
      present(32'h1111_0003, 32'h5014, 5'd0, 5'd0, 128'h55, 1'b0);
      wait_accept();
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      check("flush_drain_valid", {127'h0, out_valid}, 128'h0);

      // Killed beat D, then E
      present(32'hDDDD_0004, 32'h6004, 5'd0, 5'd0, 128'hD, 1'b1);
      wait_accept();
      check("kill_out_valid", {127'h0, out_valid}, 128'h0);
      check("kill_out_instr", {96'h0, out_instr}, 128'h0);
      present(32'hEEEE_0005, 32'h6008, 5'd0, 5'd0, 128'hE, 1'b0);
      wait_accept();
      check("after_kill_valid", {127'h0, out_valid}, 128'h1);
      check("after_kill_instr", {96'h0, out_instr}, 128'hEEEE_0005);
      step();

`ifdef STALL_PERF_CNT_EN
      // Stall counter
      do_reset();
      check("stall_start", {96'h0, stall_cnt}, 128'h0);
      out_ready = 1'b0;
      present(32'h7777_0001, 32'h7004, 5'd0, 5'd0, 128'h77, 1'b0);
      wait_accept();
      repeat (7) step();
      check("stall_seven", {96'h0, stall_cnt}, 128'd7);
      out_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      check("stall_after_flush", {96'h0, stall_cnt}, 128'd7);
      do_reset();
      check("stall_after_reset", {96'h0, stall_cnt}, 128'h0);
`endif

      // Random traffic through the scoreboard
      for (int i = 0; i < 400; i++) begin
         logic [4:0] codes [5];
         codes[0] = 5'd0; codes[1] = 5'd4; codes[2] = 5'd10; codes[3] = 5'd12; codes[4] = 5'd31;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_kill   = ($urandom_range(0, 7) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_instr  = $urandom;
         in_pc4    = $urandom;
         in_exc    = (($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 4)] : 5'd0);
         loc_exc   = (($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 4)] : 5'd0);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end
      in_valid  = 1'b0;
      in_kill   = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      repeat (4) step();
      check("final_sb_empty", {96'h0, 32'(sb.size())}, 128'h0);
      check("final_out_valid", {127'h0, out_valid}, 128'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
